// File: rtl/chain_pkg.sv
// Shared constants for the chaining DP scoring blocks.
package chain_pkg;
  localparam int COORD_W_DEF = 32;
  localparam int SCORE_W_DEF = 32;
  localparam int LOG2_LAT = 3;
  localparam int Q_FRAC = 8;
  localparam logic [SCORE_W_DEF-1:0] NEG_INF = {1'b1, {(SCORE_W_DEF-1){1'b0}}};
endpackage

// File: rtl/chain_delay_line.sv
// Async-reset shift register that aligns pair state with the ilog2 latency.
// Bit 0 of each word is treated as that stage's valid flag and ORed into lead_or.
module chain_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         lead_or
);
  logic [DEPTH-1:0][W-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

  always_comb begin
    lead_or = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      lead_or = lead_or | sr[i][0];
    end
  end
endmodule

// File: rtl/chain_gap_score.sv
// Scores one anchor pair (i, j): range/band rejection, linear + log gap cost, f[j] + sc.
// Handshake: in_valid/out_valid are plain per-cycle flags, no ready; a pair sampled at edge k appears at edge k+5.
module chain_gap_score
  import chain_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int SCORE_W  = SCORE_W_DEF,
  parameter int SPAN_W   = 8,
  parameter int IDX_W    = 16,
  parameter int LOG2_LAT = chain_pkg::LOG2_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] in_ri,
  input  logic [COORD_W-1:0] in_qi,
  input  logic [COORD_W-1:0] in_rj,
  input  logic [COORD_W-1:0] in_qj,
  input  logic [SPAN_W-1:0]  in_span,
  input  logic [SCORE_W-1:0] in_fj,
  input  logic [IDX_W-1:0]   in_tag,
  input  logic [COORD_W-1:0] cfg_max_dist_x,
  input  logic [COORD_W-1:0] cfg_max_dist_y,
  input  logic [COORD_W-1:0] cfg_bw,
  input  logic [15:0]        cfg_avg_qspan,
  output logic [31:0]        dd_o,
  input  logic [4:0]         log2_i,
  output logic               out_valid,
  output logic [SCORE_W-1:0] out_score,
  output logic               out_reject,
  output logic [IDX_W-1:0]   out_tag,
  output logic               busy
);
  localparam int PROD_W = COORD_W + 16;
  localparam int DW     = IDX_W + SCORE_W + SPAN_W + COORD_W + COORD_W + 2;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  // S1 combinational geometry
  logic signed [COORD_W:0]   dq, dr;
  logic signed [COORD_W+1:0] diff;
  logic [COORD_W+1:0]        dd_full;
  logic [COORD_W-1:0]        min_d_c;
  logic                      rej_c;

  always_comb begin
    dq      = $signed({1'b0, in_qi}) - $signed({1'b0, in_qj});
    dr      = $signed({1'b0, in_ri}) - $signed({1'b0, in_rj});
    diff    = dr - dq;
    dd_full = diff[COORD_W+1] ? $unsigned(-diff) : $unsigned(diff);
    min_d_c = (dq < dr) ? dq[COORD_W-1:0] : dr[COORD_W-1:0];
    rej_c   = dq[COORD_W] || (dq == '0) || dr[COORD_W] || (dr == '0)
           || (dq[COORD_W-1:0] > cfg_max_dist_x)
           || (dr[COORD_W-1:0] > cfg_max_dist_y)
           || (dd_full > {2'b00, cfg_bw});
  end

  logic               s1_v, s1_rej;
  logic [COORD_W-1:0] s1_dd, s1_min;
  logic [SPAN_W-1:0]  s1_span;
  logic [SCORE_W-1:0] s1_fj;
  logic [IDX_W-1:0]   s1_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_rej  <= 1'b0;
      s1_dd   <= '0;
      s1_min  <= '0;
      s1_span <= '0;
      s1_fj   <= '0;
      s1_tag  <= '0;
    end else begin
      s1_v    <= in_valid;
      s1_rej  <= rej_c;
      s1_dd   <= dd_full[COORD_W-1:0];
      s1_min  <= min_d_c;
      s1_span <= in_span;
      s1_fj   <= in_fj;
      s1_tag  <= in_tag;
    end
  end

  assign dd_o = 32'(s1_dd);

  // D1..D3: carry the pair while the external ilog2 unit works on dd_o
  logic [DW-1:0]      d_in, d_out;
  logic               d_busy, d_v, d_rej;
  logic [COORD_W-1:0] d_dd, d_min;
  logic [SPAN_W-1:0]  d_span;
  logic [SCORE_W-1:0] d_fj;
  logic [IDX_W-1:0]   d_tag;

  assign d_in = {s1_tag, s1_fj, s1_span, s1_min, s1_dd, s1_rej, s1_v};
  assign {d_tag, d_fj, d_span, d_min, d_dd, d_rej, d_v} = d_out;

  chain_delay_line #(.W(DW), .DEPTH(LOG2_LAT)) u_delay (
    .clk     (clk),
    .reset   (reset),
    .d       (d_in),
    .q       (d_out),
    .lead_or (d_busy)
  );

  // S4 gap cost
  logic [PROD_W-1:0]  prod;
  logic [SCORE_W-1:0] gap, sc_c;
  logic [COORD_W-1:0] span_ext, min_cs;

  always_comb begin
    prod     = PROD_W'(d_dd) * PROD_W'(cfg_avg_qspan);
    gap      = SCORE_W'(prod >> Q_FRAC) + SCORE_W'(log2_i >> 1);
    span_ext = COORD_W'(d_span);
    min_cs   = (d_min < span_ext) ? d_min : span_ext;
    sc_c     = SCORE_W'(min_cs) - gap;
  end

  logic               s4_v, s4_rej;
  logic [SCORE_W-1:0] s4_sc, s4_fj;
  logic [IDX_W-1:0]   s4_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s4_v   <= 1'b0;
      s4_rej <= 1'b0;
      s4_sc  <= '0;
      s4_fj  <= '0;
      s4_tag <= '0;
    end else begin
      s4_v   <= d_v;
      s4_rej <= d_rej;
      s4_sc  <= sc_c;
      s4_fj  <= d_fj;
      s4_tag <= d_tag;
    end
  end

  // S5 saturating add; outputs hold between valid results
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] sat;

  always_comb begin
    sum = {s4_fj[SCORE_W-1], s4_fj} + {s4_sc[SCORE_W-1], s4_sc};
    if (sum[SCORE_W] != sum[SCORE_W-1]) begin
      sat = sum[SCORE_W] ? SCORE_MIN : SCORE_MAX;
    end else begin
      sat = sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_score  <= '0;
      out_reject <= 1'b0;
      out_tag    <= '0;
    end else begin
      out_valid <= s4_v;
      if (s4_v) begin
        out_score  <= s4_rej ? SCORE_MIN : sat;
        out_reject <= s4_rej;
        out_tag    <= s4_tag;
      end
    end
  end

  assign busy = s1_v | d_busy | s4_v;
endmodule

// File: tb/tb_chain_gap_score.sv
// Directed bench for chain_gap_score with a behavioural 3-cycle ilog2 beside it.
module tb_chain_gap_score;
  logic        clk, rst;
  logic        in_valid;
  logic [31:0] in_ri, in_qi, in_rj, in_qj;
  logic [7:0]  in_span;
  logic [31:0] in_fj;
  logic [15:0] in_tag;
  logic [31:0] cfg_max_dist_x, cfg_max_dist_y, cfg_bw;
  logic [15:0] cfg_avg_qspan;
  logic [31:0] dd_o;
  logic [4:0]  log2_i;
  logic        out_valid, out_reject, busy;
  logic [31:0] out_score;
  logic [15:0] out_tag;

  int n_total = 0;
  int n_bad   = 0;
  logic        mon_en = 1'b0;
  logic [48:0] exp_q[$];
  logic [48:0] e;
  logic [5:0]  vhist;
  logic [4:0]  l0, l1, l2;

  chain_gap_score dut (
    .clk(clk), .reset(rst), .in_valid(in_valid),
    .in_ri(in_ri), .in_qi(in_qi), .in_rj(in_rj), .in_qj(in_qj),
    .in_span(in_span), .in_fj(in_fj), .in_tag(in_tag),
    .cfg_max_dist_x(cfg_max_dist_x), .cfg_max_dist_y(cfg_max_dist_y),
    .cfg_bw(cfg_bw), .cfg_avg_qspan(cfg_avg_qspan),
    .dd_o(dd_o), .log2_i(log2_i),
    .out_valid(out_valid), .out_score(out_score), .out_reject(out_reject),
    .out_tag(out_tag), .busy(busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ilog2 model: floor(log2(v)), 0 for v = 0
  function automatic logic [4:0] flog2(input logic [31:0] v);
    logic [4:0] r = 5'd0;
    for (int b = 0; b < 32; b++) if (v[b]) r = 5'(b);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      l0 <= '0; l1 <= '0; l2 <= '0;
      vhist <= '0;
    end else begin
      l0 <= flog2(dd_o); l1 <= l0; l2 <= l1;
      vhist <= {vhist[4:0], in_valid};
    end
  end
  assign log2_i = l2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every cycle out_valid must mirror in_valid from 5 edges earlier
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid_align", out_valid, vhist[5]);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("score", out_score, e[47:16]);
          check("reject", out_reject, e[48]);
          check("tag", out_tag, e[15:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [31:0] ri, qi, rj, qj, input logic [7:0] span,
                      input logic [31:0] fj, input logic [15:0] tag,
                      input logic [31:0] e_score, input logic e_rej);
    @(negedge clk);
    in_valid = 1'b1;
    in_ri = ri; in_qi = qi; in_rj = rj; in_qj = qj;
    in_span = span; in_fj = fj; in_tag = tag;
    exp_q.push_back({e_rej, e_score, tag});
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int cnt = 0;
    bubble(1);
    while (exp_q.size() != 0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("drain", exp_q.size(), 0);
    bubble(1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_ri = '0; in_qi = '0; in_rj = '0; in_qj = '0;
    in_span = '0; in_fj = '0; in_tag = '0;
    cfg_max_dist_x = 32'd5000; cfg_max_dist_y = 32'd5000;
    cfg_bw = 32'd500; cfg_avg_qspan = 16'h0100;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dd_o", dd_o, 0);
    check("rst_out_score", out_score, 0);
    check("rst_out_reject", out_reject, 0);
    check("rst_out_tag", out_tag, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    bubble(2);

    // basic pair: dd=20, log2=4, gap=22, sc=-7
    send(1000, 500, 900, 420, 15, 100, 16'h0001, 93, 1'b0);
    @(posedge clk); #1;
    check("dd_o_pair1", dd_o, 20);
    check("busy_inflight", busy, 1);
    drain();
    repeat (3) @(negedge clk);
    check("hold_score", out_score, 93);
    check("hold_tag", out_tag, 16'h0001);
    check("idle_busy", busy, 0);

    // dd=0: no gap cost
    send(1000, 500, 900, 400, 15, 100, 16'h0002, 115, 1'b0);
    // rejections
    send(1000, 500, 900, 500, 15, 100, 16'h0003, 32'h80000000, 1'b1);  // dq = 0
    send(800, 500, 900, 400, 15, 100, 16'h0004, 32'h80000000, 1'b1);   // dr < 0
    send(6000, 5000, 0, 0, 15, 100, 16'h0005, 32'h80000000, 1'b1);     // dr > max
    // band boundary: dd=500 accepted (gap=504, sc=-489), dd=501 rejected
    send(1000, 1000, 0, 500, 15, 1000, 16'h0006, 511, 1'b0);
    send(1000, 1000, 0, 501, 15, 1000, 16'h0007, 32'h80000000, 1'b1);
    drain();

    // narrow band turns pair 1 into a reject
    cfg_bw = 32'd10;
    send(1000, 500, 900, 420, 15, 100, 16'h0008, 32'h80000000, 1'b1);
    drain();
    cfg_bw = 32'd500;

    // avg = 1.5: gap = 30 + 2, sc = -17
    cfg_avg_qspan = 16'h0180;
    send(1000, 500, 900, 420, 15, 100, 16'h0009, 83, 1'b0);
    drain();
    cfg_avg_qspan = 16'h0100;

    // saturation both ways
    send(1000, 500, 900, 400, 15, 32'h7FFFFFFA, 16'h000A, 32'h7FFFFFFF, 1'b0);
    send(1000, 500, 900, 420, 0, 32'h80000005, 16'h000B, 32'h80000000, 1'b0);
    drain();

    // back-to-back, then alternating bubbles
    for (int i = 0; i < 8; i++)
      send(1000, 500, 900, 420, 15, 32'(1000 + i), 16'(16 + i), 32'(993 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(1000, 500, 900, 420, 15, 32'(2000 + i), 16'(32 + i), 32'(1993 + i), 1'b0);
      bubble(1);
    end
    drain();

    // reset mid-cycle with 3 pairs in flight
    for (int i = 0; i < 3; i++)
      send(1000, 500, 900, 420, 15, 100, 16'(64 + i), 93, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_dd_o", dd_o, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bubble(10);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
